// File: rtl/grid_check_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : grid_check_ctrl
//  Purpose  : Serial 3x3 Sudoku box checker. Nine 4-bit digits are loaded
//             over a valid/ready handshake, then scanned one per cycle for
//             range (1..9) and duplicate violations. Pass/fail, the error
//             class and the index of the first offending digit are held
//             until the next accepted start.
//  Config   : `define CHECK_DUP_EN enables duplicate detection (9-bit seen
//             mask). When undefined only the range check is performed and
//             err_code 2'b10 is never produced; latency is unchanged.
//  Revision : 1.0 - initial release
// ============================================================================
module grid_check_ctrl #(
  parameter int NUM_DIGITS = 9
) (
  input  logic       clock,
  input  logic       reset_L,
  input  logic       start,
  input  logic [3:0] digit_in,
  input  logic       digit_valid,
  output logic       digit_ready,
  output logic       busy,
  output logic       done,
  output logic       grid_valid,
  output logic [1:0] err_code,
  output logic [3:0] err_index
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SCAN = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_DUP   = 2'b10;

  localparam logic [3:0] LAST_IDX  = 4'(NUM_DIGITS - 1);
  localparam logic [3:0] MAX_DIGIT = 4'(NUM_DIGITS);

  logic [1:0] state;
  logic [1:0] next_state;
  logic [3:0] load_cnt;
  logic [3:0] scan_idx;
  logic [3:0] slots [NUM_DIGITS];

  logic [3:0] cur_digit;
  logic       range_err;
  logic       dup_err;
  logic       scan_err;
  logic       scan_last;
  logic       load_last;
  logic       load_fire;
  logic       start_fire;

  // Digit under examination and the per-cycle verdict for it.
  assign cur_digit  = slots[scan_idx];
  assign range_err  = (cur_digit == 4'd0) || (cur_digit > MAX_DIGIT);
  assign scan_err   = range_err || dup_err;
  assign scan_last  = (scan_idx == LAST_IDX);
  assign load_last  = (load_cnt == LAST_IDX);
  assign load_fire  = (state == S_LOAD) && digit_valid;
  assign start_fire = (state == S_IDLE) && start;

`ifdef CHECK_DUP_EN
  logic [NUM_DIGITS-1:0] seen;
  logic [NUM_DIGITS-1:0] digit_hot;

  // One-hot decode of the current digit; stays all-zero when out of range so
  // an invalid digit can never mark or match the seen mask.
  always_comb begin
    digit_hot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit_hot[i] = (cur_digit == 4'(i + 1));
    end
  end

  assign dup_err = |(seen & digit_hot);

  // Seen mask: cleared on a new check, accumulates each clean scanned digit.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      seen <= '0;
    end else if (start_fire) begin
      seen <= '0;
    end else if ((state == S_SCAN) && !scan_err) begin
      seen <= seen | digit_hot;
    end
  end
`else
  assign dup_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: a check ends at the first error or after the last slot.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_LOAD;
      S_LOAD:  if (digit_valid && load_last) next_state = S_SCAN;
      S_SCAN:  if (scan_err || scan_last) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    digit_ready = (state == S_LOAD);
    busy        = (state != S_IDLE);
    done        = (state == S_DONE);
  end

  // Digit storage; cleared on reset so an aborted load leaves nothing behind.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        slots[i] <= 4'd0;
      end
    end else if (load_fire) begin
      slots[load_cnt] <= digit_in;
    end
  end

  // Load and scan counters.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      load_cnt <= 4'd0;
      scan_idx <= 4'd0;
    end else if (start_fire) begin
      load_cnt <= 4'd0;
      scan_idx <= 4'd0;
    end else if (load_fire) begin
      load_cnt <= load_cnt + 4'd1;
    end else if ((state == S_SCAN) && !scan_err && !scan_last) begin
      scan_idx <= scan_idx + 4'd1;
    end
  end

  // Result registers: cleared by an accepted start, written only on the
  // transition into DONE, otherwise held.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      grid_valid <= 1'b0;
      err_code   <= ERR_NONE;
      err_index  <= 4'd0;
    end else if (start_fire) begin
      grid_valid <= 1'b0;
      err_code   <= ERR_NONE;
      err_index  <= 4'd0;
    end else if (state == S_SCAN) begin
      if (range_err) begin
        err_code  <= ERR_RANGE;
        err_index <= scan_idx;
      end else if (dup_err) begin
        err_code  <= ERR_DUP;
        err_index <= scan_idx;
      end else if (scan_last) begin
        grid_valid <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_grid_check_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_grid_check_ctrl
//  Purpose  : Self-checking bench for grid_check_ctrl. Expected results come
//             from a behavioural model that walks the nine digits in order
//             and applies the range / duplicate rules directly.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_grid_check_ctrl;

  logic       clock;
  logic       reset_L;
  logic       start;
  logic [3:0] digit_in;
  logic       digit_valid;
  logic       digit_ready;
  logic       busy;
  logic       done;
  logic       grid_valid;
  logic [1:0] err_code;
  logic [3:0] err_index;

  grid_check_ctrl #(.NUM_DIGITS(9)) dut (
    .clock       (clock),
    .reset_L     (reset_L),
    .start       (start),
    .digit_in    (digit_in),
    .digit_valid (digit_valid),
    .digit_ready (digit_ready),
    .busy        (busy),
    .done        (done),
    .grid_valid  (grid_valid),
    .err_code    (err_code),
    .err_index   (err_index)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [3:0] stim [9];

  // Model outputs.
  logic       exp_gv;
  logic [1:0] exp_ec;
  logic [3:0] exp_ei;
  int         exp_lat;

  // Observations gathered by run_box.
  int          obs_lat;
  logic        obs_gv;
  logic [1:0]  obs_ec;
  logic [3:0]  obs_ei;
  logic        obs_timeout;
  logic        obs_ready_load, obs_busy_load, obs_cleared;
  logic        obs_ready_scan, obs_busy_scan;
  logic        obs_done_after, obs_busy_after, obs_hold;
  logic [10:0] obs_rst;
  int          obs_t_start;

  // First violation in index order wins; a duplicate is a repeat of a digit
  // that already appeared earlier in the box.
  task automatic compute_model();
    exp_gv = 1'b1; exp_ec = 2'b00; exp_ei = 4'd0; exp_lat = 10;
    for (int i = 0; i < 9; i++) begin
      if (stim[i] == 4'd0 || stim[i] > 4'd9) begin
        exp_gv = 1'b0; exp_ec = 2'b01; exp_ei = 4'(i); exp_lat = 2 + i;
        return;
      end
`ifdef CHECK_DUP_EN
      for (int j = 0; j < i; j++) begin
        if (stim[j] == stim[i]) begin
          exp_gv = 1'b0; exp_ec = 2'b10; exp_ei = 4'(i); exp_lat = 2 + i;
          return;
        end
      end
`endif
    end
  endtask

  task automatic set_stim(input logic [35:0] packed_digits);
    for (int i = 0; i < 9; i++) stim[i] = packed_digits[35 - 4*i -: 4];
  endtask

  // Drives one complete check starting from IDLE; optional gaps, spurious
  // start/valid noise, and an optional reset at scan cycle abort_at.
  task automatic run_box(input int gap_pct, input bit noisy, input int abort_at);
    int  idx, guard, n;
    bit  accept;
    obs_lat = -1; obs_gv = 1'bx; obs_ec = 2'bxx; obs_ei = 4'bxxxx;
    obs_timeout = 1'b0;
    obs_t_start = cyc;
    start = 1'b1; digit_valid = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    obs_ready_load = digit_ready;
    obs_busy_load  = busy;
    obs_cleared    = (grid_valid == 1'b0) && (err_code == 2'b00) && (err_index == 4'd0);
    idx = 0; guard = 0;
    while (idx < 9 && guard < 500) begin
      if (int'($urandom_range(99)) < gap_pct) begin
        digit_valid = 1'b0; digit_in = 4'($urandom);
      end else begin
        digit_valid = 1'b1; digit_in = stim[idx];
      end
      if (noisy) start = 1'($urandom_range(1));
      accept = digit_valid && digit_ready;
      @(posedge clock); #1;
      if (accept) idx++;
      guard++;
    end
    digit_valid = 1'b0;
    if (idx < 9) begin
      start = 1'b0; obs_timeout = 1'b1;
      return;
    end
    obs_ready_scan = digit_ready;
    obs_busy_scan  = busy;
    n = 1;
    while (!done && n < 40) begin
      if (abort_at > 0 && n == abort_at) begin
        start = 1'b0; digit_valid = 1'b0;
        reset_L = 1'b0;
        #1;
        obs_rst = {digit_ready, busy, done, grid_valid, err_code, err_index};
        @(posedge clock); #1;
        reset_L = 1'b1;
        @(posedge clock); #1;
        return;
      end
      if (noisy) begin
        start = 1'($urandom_range(1));
        digit_valid = 1'($urandom_range(1));
        digit_in = 4'($urandom);
      end
      @(posedge clock); #1;
      n++;
    end
    start = 1'b0; digit_valid = 1'b0;
    if (!done) begin
      obs_timeout = 1'b1;
      return;
    end
    obs_lat = n; obs_gv = grid_valid; obs_ec = err_code; obs_ei = err_index;
    @(posedge clock); #1;
    obs_done_after = done;
    obs_busy_after = busy;
    obs_hold = (grid_valid === obs_gv) && (err_code === obs_ec) && (err_index === obs_ei);
  endtask

  task automatic test_reset();
    checks++;
    if ({digit_ready, busy, done, grid_valid, err_code, err_index} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0", {digit_ready, busy, done, grid_valid, err_code, err_index});
    end
  endtask

  task automatic test_in_order();
    set_stim({4'd1,4'd2,4'd3,4'd4,4'd5,4'd6,4'd7,4'd8,4'd9});
    compute_model();
    run_box(0, 1'b0, 0);
    checks++; if (obs_timeout) begin errors++; $display("FAIL in_order timeout got 1 want 0"); end
    checks++; if (!(obs_ready_load === 1'b1 && obs_busy_load === 1'b1)) begin errors++; $display("FAIL in_order load_status got ready=%b busy=%b want 1 1", obs_ready_load, obs_busy_load); end
    checks++; if (!(obs_ready_scan === 1'b0 && obs_busy_scan === 1'b1)) begin errors++; $display("FAIL in_order scan_status got ready=%b busy=%b want 0 1", obs_ready_scan, obs_busy_scan); end
    checks++; if (obs_lat !== exp_lat) begin errors++; $display("FAIL in_order latency got %0d want %0d", obs_lat, exp_lat); end
    checks++; if ({obs_gv, obs_ec, obs_ei} !== {exp_gv, exp_ec, exp_ei}) begin errors++; $display("FAIL in_order result got gv=%b ec=%b ei=%0d want gv=%b ec=%b ei=%0d", obs_gv, obs_ec, obs_ei, exp_gv, exp_ec, exp_ei); end
    checks++; if (!(obs_done_after === 1'b0 && obs_busy_after === 1'b0)) begin errors++; $display("FAIL in_order done_pulse got done=%b busy=%b want 0 0", obs_done_after, obs_busy_after); end
    checks++; if (obs_hold !== 1'b1) begin errors++; $display("FAIL in_order hold got %b want 1", obs_hold); end
  endtask

  task automatic test_fixed(input logic [35:0] d, input string name);
    set_stim(d);
    compute_model();
    run_box(0, 1'b0, 0);
    checks++; if (obs_lat !== exp_lat) begin errors++; $display("FAIL %s latency got %0d want %0d", name, obs_lat, exp_lat); end
    checks++; if ({obs_gv, obs_ec, obs_ei} !== {exp_gv, exp_ec, exp_ei}) begin errors++; $display("FAIL %s result got gv=%b ec=%b ei=%0d want gv=%b ec=%b ei=%0d", name, obs_gv, obs_ec, obs_ei, exp_gv, exp_ec, exp_ei); end
    checks++; if (obs_hold !== 1'b1) begin errors++; $display("FAIL %s hold got %b want 1", name, obs_hold); end
  endtask

  task automatic test_stall_and_extra_start();
    for (int r = 0; r < 2; r++) begin
      if (r == 0) set_stim({4'd1,4'd2,4'd3,4'd4,4'd5,4'd6,4'd7,4'd8,4'd9});
      else        set_stim({4'd5,4'd3,4'd0,4'd1,4'd2,4'd4,4'd6,4'd7,4'd8});
      compute_model();
      run_box(40, 1'b1, 0);
      checks++; if (obs_lat !== exp_lat) begin errors++; $display("FAIL stall_%0d latency got %0d want %0d", r, obs_lat, exp_lat); end
      checks++; if ({obs_gv, obs_ec, obs_ei} !== {exp_gv, exp_ec, exp_ei}) begin errors++; $display("FAIL stall_%0d result got gv=%b ec=%b ei=%0d want gv=%b ec=%b ei=%0d", r, obs_gv, obs_ec, obs_ei, exp_gv, exp_ec, exp_ei); end
      checks++; if (obs_busy_after !== 1'b0) begin errors++; $display("FAIL stall_%0d extra_start got busy=%b want 0", r, obs_busy_after); end
    end
  endtask

  task automatic test_reset_mid_scan();
    set_stim({4'd1,4'd2,4'd3,4'd4,4'd5,4'd6,4'd7,4'd8,4'd9});
    run_box(0, 1'b0, 3);
    checks++; if (obs_rst !== 11'd0) begin errors++; $display("FAIL reset_mid_scan outputs got %b want 0", obs_rst); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_scan idle got busy=%b want 0", busy); end
    compute_model();
    run_box(0, 1'b0, 0);
    checks++; if ({obs_lat, obs_gv, obs_ec, obs_ei} !== {exp_lat, exp_gv, exp_ec, exp_ei}) begin errors++; $display("FAIL after_reset result got lat=%0d gv=%b ec=%b ei=%0d want lat=%0d gv=%b ec=%b ei=%0d", obs_lat, obs_gv, obs_ec, obs_ei, exp_lat, exp_gv, exp_ec, exp_ei); end
  endtask

  // Consecutive checks with start raised in the first IDLE cycle after DONE;
  // a check ends 9 load cycles + scan latency + 1 IDLE cycle after its start.
  task automatic test_back_to_back();
    int prev_start, prev_lat;
    set_stim({4'd2,4'd4,4'd6,4'd15,4'd1,4'd3,4'd5,4'd7,4'd9});
    compute_model();
    run_box(0, 1'b0, 0);
    prev_start = obs_t_start; prev_lat = exp_lat;
    for (int r = 0; r < 2; r++) begin
      set_stim({4'd9,4'd8,4'd7,4'd6,4'd5,4'd4,4'd3,4'd2,4'd1});
      compute_model();
      run_box(0, 1'b0, 0);
      checks++; if (obs_t_start - prev_start !== prev_lat + 10) begin errors++; $display("FAIL b2b_%0d interval got %0d want %0d", r, obs_t_start - prev_start, prev_lat + 10); end
      checks++; if (obs_cleared !== 1'b1) begin errors++; $display("FAIL b2b_%0d clear_on_start got %b want 1", r, obs_cleared); end
      checks++; if ({obs_gv, obs_ec, obs_ei} !== {exp_gv, exp_ec, exp_ei}) begin errors++; $display("FAIL b2b_%0d result got gv=%b ec=%b ei=%0d want gv=%b ec=%b ei=%0d", r, obs_gv, obs_ec, obs_ei, exp_gv, exp_ec, exp_ei); end
      prev_start = obs_t_start; prev_lat = exp_lat;
    end
  endtask

  task automatic test_random();
    int j, a, b;
    logic [3:0] tmp;
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < 9; i++) stim[i] = 4'(i + 1);
      for (int i = 8; i > 0; i--) begin
        j = int'($urandom_range(i));
        tmp = stim[i]; stim[i] = stim[j]; stim[j] = tmp;
      end
      case ($urandom_range(3))
        0: ;
        1: stim[$urandom_range(8)] = 4'($urandom_range(15));
        2: begin a = int'($urandom_range(8)); b = int'($urandom_range(8)); stim[a] = stim[b]; end
        default: begin
          stim[$urandom_range(8)] = 4'($urandom_range(15));
          a = int'($urandom_range(8)); b = int'($urandom_range(8)); stim[a] = stim[b];
        end
      endcase
      compute_model();
      run_box(int'($urandom_range(30)), 1'($urandom_range(1)), 0);
      checks++;
      if ({obs_lat, obs_gv, obs_ec, obs_ei} !== {exp_lat, exp_gv, exp_ec, exp_ei}) begin
        errors++;
        $display("FAIL random_%0d got lat=%0d gv=%b ec=%b ei=%0d want lat=%0d gv=%b ec=%b ei=%0d", it, obs_lat, obs_gv, obs_ec, obs_ei, exp_lat, exp_gv, exp_ec, exp_ei);
      end
    end
  endtask

  initial begin
    reset_L = 1'b0; start = 1'b0; digit_in = 4'd0; digit_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    reset_L = 1'b1;
    @(posedge clock); #1;
    test_in_order();
    test_fixed({4'd5,4'd3,4'd0,4'd1,4'd2,4'd4,4'd6,4'd7,4'd8}, "range_idx2");
    test_fixed({4'd1,4'd2,4'd3,4'd4,4'd5,4'd6,4'd7,4'd8,4'd3}, "dup_tail");
    test_fixed({4'd9,4'd9,4'd12,4'd1,4'd2,4'd3,4'd4,4'd5,4'd6}, "dup_before_range");
    test_fixed({4'd10,4'd1,4'd2,4'd3,4'd4,4'd5,4'd6,4'd7,4'd8}, "range_idx0_ten");
    test_fixed({4'd1,4'd2,4'd3,4'd4,4'd5,4'd6,4'd7,4'd8,4'd0}, "range_idx8_zero");
    test_stall_and_extra_start();
    test_reset_mid_scan();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
